// File: rtl/pipe_ctrl_pkg.sv
// Shared constants and types for the li/addi/j pipeline control unit.
package pipe_ctrl_pkg;

  // Opcode values; any other encoding of the opcode field is illegal.
  localparam int OP_LI   = 0;
  localparam int OP_ADDI = 1;
  localparam int OP_J    = 2;
  localparam int OP_NOP  = 3;

  // Forwarding-source select for the addi source operand.
  localparam logic [1:0] FWD_RF = 2'd0;
  localparam logic [1:0] FWD_EX = 2'd1;
  localparam logic [1:0] FWD_WB = 2'd2;

  // Jump-flush state machine.
  typedef enum logic {
    RUN   = 1'b0,
    FLUSH = 1'b1
  } state_t;

  // Decoded control bundle, MSB first: {valid, regwrite, value_to_reg, jump, illegal}.
  typedef struct packed {
    logic valid;
    logic regwrite;
    logic value_to_reg;
    logic jump;
    logic illegal;
  } ctrl_t;

endpackage

// File: rtl/pipe_ctrl_decode.sv
// Pure combinational opcode decoder; the caller qualifies with the ID valid bit.
module pipe_ctrl_decode
  import pipe_ctrl_pkg::*;
#(
  parameter int OPC_W = 2
) (
  input  logic [OPC_W-1:0] i_opcode,
  output logic             o_valid,
  output logic             o_regwrite,
  output logic             o_value_to_reg,
  output logic             o_jump,
  output logic             o_illegal
);

  // Map each defined opcode to its control bits; everything else is illegal.
  always_comb begin
    o_valid        = 1'b0;
    o_regwrite     = 1'b0;
    o_value_to_reg = 1'b0;
    o_jump         = 1'b0;
    o_illegal      = 1'b0;
    case (i_opcode)
      OPC_W'(OP_LI): begin
        o_valid    = 1'b1;
        o_regwrite = 1'b1;
      end
      OPC_W'(OP_ADDI): begin
        o_valid        = 1'b1;
        o_regwrite     = 1'b1;
        o_value_to_reg = 1'b1;
      end
      OPC_W'(OP_J): begin
        o_jump = 1'b1;
      end
      OPC_W'(OP_NOP): begin
        o_valid = 1'b0;
      end
      default: begin
        o_illegal = 1'b1;
      end
    endcase
  end

endmodule

// File: rtl/pipe_ctrl_unit.sv
// Pipelined control unit: decode in ID, ID/EX and EX/WB control registers,
// jump flush sequencing, stall bubbles, RAW forwarding select, retire counter.
//
// Flow control: an instruction in ID is consumed when valid_if_id=1 and
// stall_in=0. While stall_in=1 the PC and IF/ID hold (stall_out), ID/EX takes
// a bubble and EX/WB keeps advancing. flush_if=1 tells IF/ID to drop what it
// holds; while in FLUSH the content of ID is treated as a bubble.
module pipe_ctrl_unit
  import pipe_ctrl_pkg::*;
#(
  parameter int OPC_W       = 2,
  parameter int REG_AW      = 3,
  parameter int FLUSH_SLOTS = 1,
  parameter int CNT_W       = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              valid_if_id,
  input  logic [OPC_W-1:0]  opcode_if_id,
  input  logic [REG_AW-1:0] rd_if_id,
  input  logic [REG_AW-1:0] rs_if_id,
  input  logic              stall_in,
  output logic              stall_out,
  output logic              flush_if,
  output logic              pc_sel,
  output logic [1:0]        fwd_sel,
  output logic              illegal_op,
  output logic              valid_ex,
  output logic              regwrite_ex,
  output logic              value_to_reg_ex,
  output logic [REG_AW-1:0] rd_ex,
  output logic              valid_wb,
  output logic              regwrite_wb,
  output logic              value_to_reg_wb,
  output logic [REG_AW-1:0] rd_wb,
  output logic [CNT_W-1:0]  retired_cnt,
  output logic              dbg_state
);

  // Remaining FLUSH cycles after the jump cycle itself.
  localparam logic [1:0] SLOT_INIT = 2'(FLUSH_SLOTS - 1);

  logic              w_dec_valid;
  logic              w_dec_regwrite;
  logic              w_dec_vtr;
  logic              w_dec_jump;
  logic              w_dec_illegal;
  ctrl_t             w_dec;
  logic              w_in_flush;
  logic              w_id_live;
  logic              w_advance;
  logic              w_issue;
  logic              w_jump_take;
  logic              w_is_addi;

  state_t            r_state;
  logic [1:0]        r_slot;
  logic              r_valid_ex;
  logic              r_regwrite_ex;
  logic              r_vtr_ex;
  logic [REG_AW-1:0] r_rd_ex;
  logic              r_valid_wb;
  logic              r_regwrite_wb;
  logic              r_vtr_wb;
  logic [REG_AW-1:0] r_rd_wb;
  logic              r_illegal;
  logic [CNT_W-1:0]  r_cnt;

  pipe_ctrl_decode #(
    .OPC_W (OPC_W)
  ) u_decode (
    .i_opcode       (opcode_if_id),
    .o_valid        (w_dec_valid),
    .o_regwrite     (w_dec_regwrite),
    .o_value_to_reg (w_dec_vtr),
    .o_jump         (w_dec_jump),
    .o_illegal      (w_dec_illegal)
  );

  assign w_dec = {w_dec_valid, w_dec_regwrite, w_dec_vtr, w_dec_jump, w_dec_illegal};

  // ID content counts only outside FLUSH; it moves on only without a stall.
  assign w_in_flush  = (r_state == FLUSH);
  assign w_id_live   = valid_if_id && !w_in_flush;
  assign w_advance   = w_id_live && !stall_in;
  assign w_issue     = w_advance && w_dec.valid;
  assign w_jump_take = w_advance && w_dec.jump;
  assign w_is_addi   = valid_if_id && (opcode_if_id == OPC_W'(OP_ADDI));

  assign stall_out = stall_in;
  assign pc_sel    = w_jump_take;
  assign flush_if  = w_jump_take || w_in_flush;
  assign dbg_state = (r_state == FLUSH);

  // Forwarding source for an addi in ID; the younger EX result wins over WB.
  always_comb begin
    fwd_sel = FWD_RF;
    if (w_is_addi) begin
      if (r_valid_ex && r_regwrite_ex && (rs_if_id == r_rd_ex)) begin
        fwd_sel = FWD_EX;
      end else if (r_valid_wb && r_regwrite_wb && (rs_if_id == r_rd_wb)) begin
        fwd_sel = FWD_WB;
      end
    end
  end

  // Jump-flush FSM: count down squash slots, frozen while stalled.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= RUN;
      r_slot  <= 2'd0;
    end else begin
      case (r_state)
        RUN: begin
          if (w_jump_take && (FLUSH_SLOTS > 1)) begin
            r_state <= FLUSH;
            r_slot  <= SLOT_INIT;
          end
        end
        FLUSH: begin
          if (!stall_in) begin
            if (r_slot <= 2'd1) begin
              r_state <= RUN;
              r_slot  <= 2'd0;
            end else begin
              r_slot <= r_slot - 2'd1;
            end
          end
        end
        default: begin
          r_state <= RUN;
          r_slot  <= 2'd0;
        end
      endcase
    end
  end

  // ID/EX and EX/WB control registers, illegal pulse and retire counter.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_valid_ex    <= 1'b0;
      r_regwrite_ex <= 1'b0;
      r_vtr_ex      <= 1'b0;
      r_rd_ex       <= '0;
      r_valid_wb    <= 1'b0;
      r_regwrite_wb <= 1'b0;
      r_vtr_wb      <= 1'b0;
      r_rd_wb       <= '0;
      r_illegal     <= 1'b0;
      r_cnt         <= '0;
    end else begin
      r_valid_ex    <= w_issue;
      r_regwrite_ex <= w_issue && w_dec.regwrite;
      r_vtr_ex      <= w_issue && w_dec.value_to_reg;
      r_rd_ex       <= w_issue ? rd_if_id : '0;
      r_valid_wb    <= r_valid_ex;
      r_regwrite_wb <= r_regwrite_ex;
      r_vtr_wb      <= r_vtr_ex;
      r_rd_wb       <= r_rd_ex;
      r_illegal     <= w_advance && w_dec.illegal;
      if (r_valid_wb) begin
        r_cnt <= r_cnt + CNT_W'(1);
      end
    end
  end

  assign valid_ex        = r_valid_ex;
  assign regwrite_ex     = r_regwrite_ex;
  assign value_to_reg_ex = r_vtr_ex;
  assign rd_ex           = r_rd_ex;
  assign valid_wb        = r_valid_wb;
  assign regwrite_wb     = r_regwrite_wb;
  assign value_to_reg_wb = r_vtr_wb;
  assign rd_wb           = r_rd_wb;
  assign illegal_op      = r_illegal;
  assign retired_cnt     = r_cnt;

endmodule

// File: tb/tb_pipe_ctrl_unit.sv
// Table-driven bench for pipe_ctrl_unit; a second instance with three squash
// slots covers the longer flush and reset mid-flush.
module tb_pipe_ctrl_unit;

  // ---------------- clock / reset ----------------
  logic clk;
  logic rst_n;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- shared stimulus ----------------
  logic       valid_if_id;
  logic [2:0] opcode_if_id;
  logic [2:0] rd_if_id;
  logic [2:0] rs_if_id;
  logic       stall_in;

  // main instance: OPC_W=3, FLUSH_SLOTS=2, CNT_W=4
  logic       u_stall_out, u_flush_if, u_pc_sel, u_illegal_op;
  logic [1:0] u_fwd_sel;
  logic       u_valid_ex, u_regwrite_ex, u_vtr_ex;
  logic [2:0] u_rd_ex;
  logic       u_valid_wb, u_regwrite_wb, u_vtr_wb;
  logic [2:0] u_rd_wb;
  logic [3:0] u_retired_cnt;
  logic       u_dbg_state;

  // second instance: OPC_W=3, FLUSH_SLOTS=3, CNT_W=16
  logic        v_stall_out, v_flush_if, v_pc_sel, v_illegal_op;
  logic [1:0]  v_fwd_sel;
  logic        v_valid_ex, v_regwrite_ex, v_vtr_ex;
  logic [2:0]  v_rd_ex;
  logic        v_valid_wb, v_regwrite_wb, v_vtr_wb;
  logic [2:0]  v_rd_wb;
  logic [15:0] v_retired_cnt;
  logic        v_dbg_state;

  pipe_ctrl_unit #(
    .OPC_W(3), .REG_AW(3), .FLUSH_SLOTS(2), .CNT_W(4)
  ) u_dut (
    .clk(clk), .rst_n(rst_n), .valid_if_id(valid_if_id),
    .opcode_if_id(opcode_if_id), .rd_if_id(rd_if_id), .rs_if_id(rs_if_id),
    .stall_in(stall_in), .stall_out(u_stall_out), .flush_if(u_flush_if),
    .pc_sel(u_pc_sel), .fwd_sel(u_fwd_sel), .illegal_op(u_illegal_op),
    .valid_ex(u_valid_ex), .regwrite_ex(u_regwrite_ex),
    .value_to_reg_ex(u_vtr_ex), .rd_ex(u_rd_ex),
    .valid_wb(u_valid_wb), .regwrite_wb(u_regwrite_wb),
    .value_to_reg_wb(u_vtr_wb), .rd_wb(u_rd_wb),
    .retired_cnt(u_retired_cnt), .dbg_state(u_dbg_state)
  );

  pipe_ctrl_unit #(
    .OPC_W(3), .REG_AW(3), .FLUSH_SLOTS(3), .CNT_W(16)
  ) u_dut3 (
    .clk(clk), .rst_n(rst_n), .valid_if_id(valid_if_id),
    .opcode_if_id(opcode_if_id), .rd_if_id(rd_if_id), .rs_if_id(rs_if_id),
    .stall_in(stall_in), .stall_out(v_stall_out), .flush_if(v_flush_if),
    .pc_sel(v_pc_sel), .fwd_sel(v_fwd_sel), .illegal_op(v_illegal_op),
    .valid_ex(v_valid_ex), .regwrite_ex(v_regwrite_ex),
    .value_to_reg_ex(v_vtr_ex), .rd_ex(v_rd_ex),
    .valid_wb(v_valid_wb), .regwrite_wb(v_regwrite_wb),
    .value_to_reg_wb(v_vtr_wb), .rd_wb(v_rd_wb),
    .retired_cnt(v_retired_cnt), .dbg_state(v_dbg_state)
  );

  // ---------------- scoreboard ----------------
  int n_total = 0;
  int n_pass  = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act !== exp) $display("FAIL %s: got %0d expected %0d", name, act, exp);
    else n_pass++;
  endtask

  // ---------------- driver tasks ----------------
  task automatic drive(input int v, input int op, input int rd, input int rs, input int st);
    valid_if_id  = 1'(v);
    opcode_if_id = 3'(op);
    rd_if_id     = 3'(rd);
    rs_if_id     = 3'(rs);
    stall_in     = 1'(st);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    drive(0, 3, 0, 0, 0);
    #1 rst_n = 1'b0;
    #2;
    @(posedge clk);
    #1 rst_n = 1'b1;
  endtask

  // ---------------- vector table ----------------
  typedef struct {
    logic       v;
    logic [2:0] op, rd, rs;
    logic       st;
    logic       e_pc, e_fl;
    logic [1:0] e_fwd;
    logic       e_vex, e_rwex, e_vtrex;
    logic [2:0] e_rdex;
    logic       e_vwb;
    logic [2:0] e_rdwb;
    logic       e_ill;
  } vec_t;

  function automatic vec_t mk(int v, int op, int rd, int rs, int st,
                              int pc, int fl, int fwd,
                              int vex, int rwex, int vtrex, int rdex,
                              int vwb, int rdwb, int ill);
    vec_t m;
    m.v = 1'(v); m.op = 3'(op); m.rd = 3'(rd); m.rs = 3'(rs); m.st = 1'(st);
    m.e_pc = 1'(pc); m.e_fl = 1'(fl); m.e_fwd = 2'(fwd);
    m.e_vex = 1'(vex); m.e_rwex = 1'(rwex); m.e_vtrex = 1'(vtrex); m.e_rdex = 3'(rdex);
    m.e_vwb = 1'(vwb); m.e_rdwb = 3'(rdwb); m.e_ill = 1'(ill);
    return m;
  endfunction

  localparam int NV = 27;
  vec_t tbl[NV];

  logic [3:0] exp_cnt;
  logic       prev_vwb, prev_rwex, prev_vtrex;

  initial begin
    //            v op rd rs st  pc fl fwd  vex rw vtr rd  vwb rdwb ill
    tbl[0]  = mk(1, 0, 1, 0, 0,  0, 0, 0,   1, 1, 0, 1,   0, 0,   0); // li r1
    tbl[1]  = mk(1, 1, 3, 1, 0,  0, 0, 1,   1, 1, 1, 3,   1, 1,   0); // addi r3,r1 -> EX
    tbl[2]  = mk(1, 1, 4, 1, 0,  0, 0, 2,   1, 1, 1, 4,   1, 3,   0); // addi r4,r1 -> WB
    tbl[3]  = mk(1, 1, 5, 4, 0,  0, 0, 1,   1, 1, 1, 5,   1, 4,   0); // addi r5,r4 -> EX
    tbl[4]  = mk(1, 1, 6, 3, 0,  0, 0, 0,   1, 1, 1, 6,   1, 5,   0); // addi r6,r3 -> RF
    tbl[5]  = mk(1, 0, 2, 6, 0,  0, 0, 0,   1, 1, 0, 2,   1, 6,   0); // li: no fwd
    tbl[6]  = mk(1, 3, 7, 0, 0,  0, 0, 0,   0, 0, 0, 0,   1, 2,   0); // nop
    tbl[7]  = mk(1, 1, 1, 2, 0,  0, 0, 2,   1, 1, 1, 1,   0, 0,   0); // addi r1,r2 -> WB
    tbl[8]  = mk(1, 0, 7, 0, 1,  0, 0, 0,   0, 0, 0, 0,   1, 1,   0); // li under stall
    tbl[9]  = mk(0, 1, 0, 1, 0,  0, 0, 0,   0, 0, 0, 0,   0, 0,   0); // invalid addi
    tbl[10] = mk(1, 5, 2, 0, 0,  0, 0, 0,   0, 0, 0, 0,   0, 0,   1); // illegal op 5
    tbl[11] = mk(1, 0, 3, 0, 0,  0, 0, 0,   1, 1, 0, 3,   0, 0,   0); // li r3
    tbl[12] = mk(1, 2, 0, 0, 0,  1, 1, 0,   0, 0, 0, 0,   1, 3,   0); // j
    tbl[13] = mk(1, 0, 5, 0, 0,  0, 1, 0,   0, 0, 0, 0,   0, 0,   0); // li squashed
    tbl[14] = mk(1, 2, 0, 0, 0,  1, 1, 0,   0, 0, 0, 0,   0, 0,   0); // j
    tbl[15] = mk(1, 6, 0, 0, 0,  0, 1, 0,   0, 0, 0, 0,   0, 0,   0); // illegal squashed
    tbl[16] = mk(1, 2, 0, 0, 1,  0, 0, 0,   0, 0, 0, 0,   0, 0,   0); // j stalled
    tbl[17] = mk(1, 2, 0, 0, 1,  0, 0, 0,   0, 0, 0, 0,   0, 0,   0); // j stalled
    tbl[18] = mk(1, 2, 0, 0, 1,  0, 0, 0,   0, 0, 0, 0,   0, 0,   0); // j stalled
    tbl[19] = mk(1, 2, 0, 0, 0,  1, 1, 0,   0, 0, 0, 0,   0, 0,   0); // j taken
    tbl[20] = mk(1, 0, 6, 0, 1,  0, 1, 0,   0, 0, 0, 0,   0, 0,   0); // flush held by stall
    tbl[21] = mk(1, 2, 0, 0, 0,  0, 1, 0,   0, 0, 0, 0,   0, 0,   0); // no nested j
    tbl[22] = mk(1, 0, 4, 0, 0,  0, 0, 0,   1, 1, 0, 4,   0, 0,   0); // li r4 (back in RUN)
    tbl[23] = mk(1, 1, 7, 4, 0,  0, 0, 1,   1, 1, 1, 7,   1, 4,   0); // addi r7,r4 -> EX
    tbl[24] = mk(1, 0, 6, 0, 0,  0, 0, 0,   1, 1, 0, 6,   1, 7,   0); // li r6
    tbl[25] = mk(1, 0, 6, 0, 0,  0, 0, 0,   1, 1, 0, 6,   1, 6,   0); // li r6
    tbl[26] = mk(1, 1, 0, 6, 0,  0, 0, 1,   1, 1, 1, 0,   1, 6,   0); // EX beats WB

    // ---- reset state ----
    rst_n = 1'b1;
    drive(0, 3, 0, 0, 0);
    #1 rst_n = 1'b0;
    #2;
    chk("rst valid_ex", u_valid_ex, 0);
    chk("rst regwrite_ex", u_regwrite_ex, 0);
    chk("rst vtr_ex", u_vtr_ex, 0);
    chk("rst rd_ex", u_rd_ex, 0);
    chk("rst valid_wb", u_valid_wb, 0);
    chk("rst regwrite_wb", u_regwrite_wb, 0);
    chk("rst vtr_wb", u_vtr_wb, 0);
    chk("rst rd_wb", u_rd_wb, 0);
    chk("rst illegal_op", u_illegal_op, 0);
    chk("rst retired_cnt", u_retired_cnt, 0);
    chk("rst state", u_dbg_state, 0);
    chk("rst pc_sel", u_pc_sel, 0);
    chk("rst flush_if", u_flush_if, 0);
    chk("rst fwd_sel", u_fwd_sel, 0);
    @(posedge clk);
    #1 rst_n = 1'b1;

    // ---- table ----
    exp_cnt = 4'd0; prev_vwb = 1'b0; prev_rwex = 1'b0; prev_vtrex = 1'b0;
    for (int i = 0; i < NV; i++) begin
      drive(tbl[i].v, tbl[i].op, tbl[i].rd, tbl[i].rs, tbl[i].st);
      #1;
      chk($sformatf("r%0d pc_sel", i), u_pc_sel, tbl[i].e_pc);
      chk($sformatf("r%0d flush_if", i), u_flush_if, tbl[i].e_fl);
      chk($sformatf("r%0d fwd_sel", i), u_fwd_sel, tbl[i].e_fwd);
      chk($sformatf("r%0d stall_out", i), u_stall_out, tbl[i].st);
      step();
      if (prev_vwb) exp_cnt = exp_cnt + 4'd1;
      chk($sformatf("r%0d valid_ex", i), u_valid_ex, tbl[i].e_vex);
      chk($sformatf("r%0d regwrite_ex", i), u_regwrite_ex, tbl[i].e_rwex);
      chk($sformatf("r%0d vtr_ex", i), u_vtr_ex, tbl[i].e_vtrex);
      if (tbl[i].e_vex) chk($sformatf("r%0d rd_ex", i), u_rd_ex, tbl[i].e_rdex);
      chk($sformatf("r%0d valid_wb", i), u_valid_wb, tbl[i].e_vwb);
      chk($sformatf("r%0d regwrite_wb", i), u_regwrite_wb, prev_rwex);
      chk($sformatf("r%0d vtr_wb", i), u_vtr_wb, prev_vtrex);
      if (tbl[i].e_vwb) chk($sformatf("r%0d rd_wb", i), u_rd_wb, tbl[i].e_rdwb);
      chk($sformatf("r%0d illegal_op", i), u_illegal_op, tbl[i].e_ill);
      chk($sformatf("r%0d retired_cnt", i), u_retired_cnt, exp_cnt);
      prev_vwb   = tbl[i].e_vwb;
      prev_rwex  = tbl[i].e_rwex;
      prev_vtrex = tbl[i].e_vtrex;
    end

    // ---- reset in the middle of a 3-slot flush ----
    do_reset();
    drive(1, 0, 3, 0, 0); step();                 // li r3
    drive(1, 2, 0, 0, 0); #1;                      // j
    chk("mf j pc_sel", v_pc_sel, 1);
    chk("mf j flush_if", v_flush_if, 1);
    step();
    drive(1, 0, 5, 0, 0); #1;
    chk("mf slot1 flush_if", v_flush_if, 1);
    chk("mf slot1 state", v_dbg_state, 1);
    step();
    drive(1, 0, 5, 0, 0); #1;
    chk("mf slot2 flush_if", v_flush_if, 1);
    chk("mf slot2 state", v_dbg_state, 1);
    chk("mf retired before rst", v_retired_cnt, 1);
    valid_if_id = 1'b0;
    rst_n = 1'b0;
    #1;
    chk("mf rst flush_if", v_flush_if, 0);
    chk("mf rst state", v_dbg_state, 0);
    chk("mf rst retired", v_retired_cnt, 0);
    chk("mf rst valid_ex", v_valid_ex, 0);
    chk("mf rst valid_wb", v_valid_wb, 0);
    chk("mf rst main retired", u_retired_cnt, 0);
    @(posedge clk);
    #1 rst_n = 1'b1;
    drive(1, 0, 2, 0, 0); step();                 // li r2 after release
    chk("post li valid_ex", v_valid_ex, 1);
    chk("post li regwrite_ex", v_regwrite_ex, 1);
    chk("post li vtr_ex", v_vtr_ex, 0);
    chk("post li rd_ex", v_rd_ex, 2);
    chk("post li main valid_ex", u_valid_ex, 1);

    // ---- flush length: 3 slots vs 2 slots ----
    drive(1, 2, 0, 0, 0); #1;
    chk("fl0 3slot", v_flush_if, 1);
    chk("fl0 2slot", u_flush_if, 1);
    step();
    drive(1, 0, 1, 0, 0); #1;
    chk("fl1 3slot", v_flush_if, 1);
    chk("fl1 2slot", u_flush_if, 1);
    step();
    drive(1, 0, 1, 0, 0); #1;
    chk("fl2 3slot", v_flush_if, 1);
    chk("fl2 2slot", u_flush_if, 0);
    step();
    chk("fl2 2slot valid_ex", u_valid_ex, 1);
    chk("fl2 3slot valid_ex", v_valid_ex, 0);
    drive(1, 0, 1, 0, 0); #1;
    chk("fl3 3slot", v_flush_if, 0);
    step();
    chk("fl3 3slot valid_ex", v_valid_ex, 1);

    // ---- retire counter wrap ----
    do_reset();
    for (int k = 0; k < 17; k++) begin
      drive(1, 0, 3'(k), 0, 0);
      step();
    end
    drive(1, 3, 0, 0, 0); step();
    drive(1, 3, 0, 0, 0); step();
    chk("wrap 4b retired_cnt", u_retired_cnt, 1);
    chk("wrap 16b retired_cnt", v_retired_cnt, 17);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/pipe_ctrl_unit.md
Name: pipe_ctrl_unit

Overview:
Parametrised, pipelined control unit for the li/addi/j processor. It decodes the IF/ID opcode and registers control bits through the ID/EX and EX/WB stages. It also handles jump flushes with a configurable number of squash slots, inserts bubbles on external stall, selects RAW forwarding sources, and counts retired instructions. It sits between the IF/ID register and the datapath muxes, and replaces the flat combinational decoder.

Parameters:
OPC_W, 2, opcode width (>=2); opcodes not listed in the package decode as illegal.
REG_AW, 3, register address width.
FLUSH_SLOTS, 1, number of fetched slots squashed after a taken jump (1..3).
CNT_W, 16, width of the retired-instruction counter.

Ports:
clk  in  1  clock, rising edge.
rst_n  in  1  asynchronous active-low reset.
valid_if_id  in  1  IF/ID holds an instruction.
opcode_if_id  in  OPC_W  opcode in ID.
rd_if_id  in  REG_AW  destination register in ID.
rs_if_id  in  REG_AW  source register in ID (used by addi).
stall_in  in  1  external stall request (e.g. memory not ready).
stall_out  out  1  hold PC and IF/ID; combinational, equals stall_in.
flush_if  out  1  squash the IF/ID content this cycle.
pc_sel  out  1  select jump target; 1-cycle pulse.
fwd_sel  out  2  0 = regfile, 1 = EX result, 2 = WB result; combinational.
illegal_op  out  1  registered 1-cycle pulse on an undefined opcode in ID.
valid_ex, regwrite_ex, value_to_reg_ex  out  1 each  ID/EX control bits.
rd_ex  out  REG_AW  ID/EX destination.
valid_wb, regwrite_wb, value_to_reg_wb  out  1 each  EX/WB control bits.
rd_wb  out  REG_AW  EX/WB destination.
retired_cnt  out  CNT_W  count of valid instructions leaving WB.

Behaviour:
- Decode uses package constants OP_LI=0, OP_ADDI=1, OP_J=2, OP_NOP=3.
  - li: regwrite=1, value_to_reg=0.
  - addi: regwrite=1, value_to_reg=1.
  - j: regwrite=0, jump. The jump issues no ID/EX valid; it is consumed in ID.
  - nop and illegal: bubble (valid=0, regwrite=0).
- Reset (rst_n=0, async): every registered output is 0, state=RUN, slot counter=0, retired_cnt=0. Reset mid-flush abandons the flush.
- State machine RUN/FLUSH:
  - RUN, with a valid j in ID and stall_in=0:
    - pc_sel=1 and flush_if=1 in the same cycle (combinational from ID).
    - Go to FLUSH with slot counter = FLUSH_SLOTS-1.
    - If FLUSH_SLOTS=1, remain in RUN. The single squash is already covered by flush_if in the jump cycle.
  - FLUSH: every cycle flush_if=1 and the ID content becomes a bubble, including a j (no nested jump). The counter decrements; at 0, return to RUN.
  - stall_in=1 in FLUSH: counter and state hold; flush_if stays 1.
- Stall (stall_in=1, RUN):
  - ID/EX is loaded with a bubble.
  - EX/WB advances normally.
  - A j in ID is not taken (pc_sel=0) until the first cycle with stall_in=0.
- Pipeline: ID/EX is loaded from decode each cycle; EX/WB takes ID/EX unchanged. Latency ID->EX is 1 cycle; ID->WB is 2 cycles.
- Forwarding, evaluated only for a valid addi in ID, with priority EX over WB:
  - rs_if_id==rd_ex && regwrite_ex && valid_ex -> 1.
  - else rs_if_id==rd_wb && regwrite_wb && valid_wb -> 2.
  - else 0. Any non-addi opcode gives 0.
- illegal_op is registered; it pulses the cycle after the undefined opcode is in ID, and only if that slot was not squashed.
- retired_cnt increments when valid_wb=1 at a clock edge and wraps modulo 2^CNT_W.
- Simultaneous stall_in and jump: stall wins; the jump is deferred.

Decomposition:
- Package pipe_ctrl_pkg: OP_* constants, FWD_RF/FWD_EX/FWD_WB encodings, state enum localparams RUN/FLUSH, and a ctrl-bundle field order.
- One sub-module, pipe_ctrl_decode: combinational opcode -> {valid, regwrite, value_to_reg, jump, illegal}. Everything else stays in pipe_ctrl_unit.

Test Plan:
1. Reset with rst_n=0 mid-flush (FLUSH_SLOTS=3, after a j) -> all outputs 0 asynchronously; after release, an li r2 gives valid_ex=1, regwrite_ex=1, value_to_reg_ex=0, rd_ex=2 one cycle later.
2. li r1; addi r3,r1; addi r4,r1 back-to-back -> fwd_sel=1 for the first addi, 2 for the second; rd_wb=1 two cycles after li is in ID.
3. j followed by valid li, li with FLUSH_SLOTS=2 -> pc_sel pulses 1 cycle; flush_if high 2 cycles; neither li reaches valid_ex; retired_cnt unchanged.
4. j in ID with stall_in=1 for 3 cycles -> pc_sel=0 throughout and ID/EX bubbles; pc_sel=1 on the first cycle stall_in=0.
5. OPC_W=3, opcode 5 -> illegal_op pulse next cycle, valid_ex=0; the same opcode during FLUSH -> no pulse.
6. CNT_W=4, 17 valid li retire -> retired_cnt=1 (wrap).
